// File: rtl/video_bus_bridge.sv
// Registered video-bus bridge: decodes to frame buffer or slot array, strobe one cycle after accept.
// Read data returns RD_LAT+2 cycles after accept; video_ready drops while a read is outstanding.
module video_bus_bridge #(
  parameter int N_SLOTS  = 8,
  parameter int SLOT_AW  = 14,
  parameter int FRAME_AW = 20,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        video_cs,
  input  logic                        video_wr,
  input  logic                        video_rd,
  input  logic [FRAME_AW:0]           video_addr,
  input  logic [DW-1:0]               video_wr_data,
  output logic                        video_ready,
  output logic                        video_rd_valid,
  output logic [DW-1:0]               video_rd_data,
  output logic                        frame_cs,
  output logic                        frame_wr,
  output logic                        frame_rd,
  output logic [FRAME_AW-1:0]         frame_addr,
  output logic [DW-1:0]               frame_wr_data,
  input  logic [DW-1:0]               frame_rd_data,
  output logic [N_SLOTS-1:0]          slot_cs_array,
  output logic [N_SLOTS-1:0]          slot_mem_wr_array,
  output logic [N_SLOTS-1:0]          slot_mem_rd_array,
  output logic [N_SLOTS*SLOT_AW-1:0]  slot_reg_addr_array,
  output logic [N_SLOTS*DW-1:0]       slot_wr_data_array,
  input  logic [N_SLOTS*DW-1:0]       slot_rd_data_array,
  input  logic                        err_clr,
  output logic                        err_flag,
  output logic [15:0]                 err_count
);

  localparam int SW = $clog2(N_SLOTS);
  localparam logic [SW:0] NS = N_SLOTS[SW:0];
  localparam logic [2:0] LAT = RD_LAT[2:0];

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_q;
  logic [2:0]          wait_cnt_q;
  logic                ready_q;
  logic                rd_valid_q;
  logic [DW-1:0]       rd_data_q;
  logic                rd_frame_q;
  logic                rd_unpop_q;
  logic [SW-1:0]       rd_idx_q;

  logic                frame_cs_q, frame_wr_q, frame_rd_q;
  logic [FRAME_AW-1:0] frame_addr_q;
  logic [DW-1:0]       frame_wdat_q;
  logic [N_SLOTS-1:0]  slot_cs_q, slot_wr_q, slot_rd_q;
  logic [SLOT_AW-1:0]  slot_addr_q;
  logic [DW-1:0]       slot_wdat_q;
  logic                err_flag_q;
  logic [15:0]         err_count_q;

  logic                frame_sel, slot_unpop, slot_hit;
  logic                acc, acc_wr, acc_rd, err_evt;
  logic [SW-1:0]       slot_idx;
  logic [N_SLOTS-1:0]  slot_oh;
  logic                frame_cs_d, frame_wr_d, frame_rd_d;
  logic [N_SLOTS-1:0]  slot_cs_d, slot_wr_d, slot_rd_d;
  logic [DW-1:0]       rd_mux;

  assign frame_sel  = video_addr[FRAME_AW];
  assign slot_idx   = video_addr[SLOT_AW+SW-1:SLOT_AW];
  assign slot_unpop = !frame_sel && ({1'b0, slot_idx} >= NS);
  // A simultaneous wr+rd request is treated as a write.
  assign acc        = video_cs && ready_q && (video_wr || video_rd);
  assign acc_wr     = acc && video_wr;
  assign acc_rd     = acc && !video_wr;
  assign err_evt    = acc && slot_unpop;
  assign slot_hit   = acc && !frame_sel && !slot_unpop;
  assign slot_oh    = {{(N_SLOTS-1){1'b0}}, 1'b1} << slot_idx;

  always_comb begin
    frame_cs_d = acc && frame_sel;
    frame_wr_d = acc_wr && frame_sel;
    frame_rd_d = acc_rd && frame_sel;
    slot_cs_d  = slot_hit ? slot_oh : '0;
    slot_wr_d  = (slot_hit && video_wr) ? slot_oh : '0;
    slot_rd_d  = (slot_hit && !video_wr) ? slot_oh : '0;
  end

  // Unpopulated slots read back as zero.
  always_comb begin
    rd_mux = '0;
    if (!rd_unpop_q) begin
      if (rd_frame_q) begin
        rd_mux = frame_rd_data;
      end else begin
        for (int i = 0; i < N_SLOTS; i++) begin
          if (int'(rd_idx_q) == i) rd_mux = slot_rd_data_array[i*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cs_q   <= 1'b0;
      frame_wr_q   <= 1'b0;
      frame_rd_q   <= 1'b0;
      frame_addr_q <= '0;
      frame_wdat_q <= '0;
      slot_cs_q    <= '0;
      slot_wr_q    <= '0;
      slot_rd_q    <= '0;
      slot_addr_q  <= '0;
      slot_wdat_q  <= '0;
      err_flag_q   <= 1'b0;
      err_count_q  <= '0;
    end else begin
      frame_cs_q <= frame_cs_d;
      frame_wr_q <= frame_wr_d;
      frame_rd_q <= frame_rd_d;
      slot_cs_q  <= slot_cs_d;
      slot_wr_q  <= slot_wr_d;
      slot_rd_q  <= slot_rd_d;
      if (frame_cs_d) frame_addr_q <= video_addr[FRAME_AW-1:0];
      if (frame_wr_d) frame_wdat_q <= video_wr_data;
      if (slot_hit) slot_addr_q <= video_addr[SLOT_AW-1:0];
      if (slot_hit && video_wr) slot_wdat_q <= video_wr_data;
      // An error event outranks a same-cycle clear.
      if (err_evt) err_flag_q <= 1'b1;
      else if (err_clr) err_flag_q <= 1'b0;
      if (err_evt && (err_count_q != 16'hFFFF)) err_count_q <= err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      ready_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_frame_q <= 1'b0;
      rd_unpop_q <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_RESP: begin
          if (acc_rd) begin
            state_q    <= S_WAIT;
            wait_cnt_q <= '0;
            ready_q    <= 1'b0;
            rd_frame_q <= frame_sel;
            rd_unpop_q <= slot_unpop;
            rd_idx_q   <= slot_idx;
          end else begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          // WAIT spans the strobe cycle plus RD_LAT; data is sampled on its last cycle.
          if (wait_cnt_q == LAT) begin
            state_q    <= S_RESP;
            ready_q    <= 1'b1;
            rd_valid_q <= 1'b1;
            rd_data_q  <= rd_mux;
          end else begin
            wait_cnt_q <= wait_cnt_q + 3'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign video_ready         = ready_q;
  assign video_rd_valid      = rd_valid_q;
  assign video_rd_data       = rd_data_q;
  assign frame_cs            = frame_cs_q;
  assign frame_wr            = frame_wr_q;
  assign frame_rd            = frame_rd_q;
  assign frame_addr          = frame_addr_q;
  assign frame_wr_data       = frame_wdat_q;
  assign slot_cs_array       = slot_cs_q;
  assign slot_mem_wr_array   = slot_wr_q;
  assign slot_mem_rd_array   = slot_rd_q;
  assign slot_reg_addr_array = {N_SLOTS{slot_addr_q}};
  assign slot_wr_data_array  = {N_SLOTS{slot_wdat_q}};
  assign err_flag            = err_flag_q;
  assign err_count           = err_count_q;

endmodule

// File: tb/tb_video_bus_bridge.sv
// Bench for video_bus_bridge: an 8-slot and a 6-slot instance share one request bus.
module tb_video_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        video_cs, video_wr, video_rd, err_clr;
  logic [20:0] video_addr;
  logic [31:0] video_wr_data;
  logic [31:0] frame_rd_data;
  logic [255:0] slot_rd8;
  logic [191:0] slot_rd6;

  logic         ready8, rd_valid8, frame_cs8, frame_wr8, frame_rd8, err_flag8;
  logic [31:0]  rd_data8, frame_wdat8;
  logic [19:0]  frame_addr8;
  logic [7:0]   slot_cs8, slot_wr8, slot_rd8_o;
  logic [111:0] slot_addr8;
  logic [255:0] slot_wdat8;
  logic [15:0]  err_count8;

  logic         ready6, rd_valid6, frame_cs6, frame_wr6, frame_rd6, err_flag6;
  logic [31:0]  rd_data6, frame_wdat6;
  logic [19:0]  frame_addr6;
  logic [5:0]   slot_cs6, slot_wr6, slot_rd6_o;
  logic [83:0]  slot_addr6;
  logic [191:0] slot_wdat6;
  logic [15:0]  err_count6;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b1;

  typedef struct {
    bit          frame;
    bit          wr;
    int          idx;
    logic [19:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sq[$];
  logic [31:0] rq[$];
  exp_t        me;
  logic [7:0]  oh;

  always #5 clk = ~clk;

  video_bus_bridge #(.N_SLOTS(8)) u8 (
    .clk(clk), .reset(reset), .video_cs(video_cs), .video_wr(video_wr), .video_rd(video_rd),
    .video_addr(video_addr), .video_wr_data(video_wr_data), .video_ready(ready8),
    .video_rd_valid(rd_valid8), .video_rd_data(rd_data8), .frame_cs(frame_cs8),
    .frame_wr(frame_wr8), .frame_rd(frame_rd8), .frame_addr(frame_addr8),
    .frame_wr_data(frame_wdat8), .frame_rd_data(frame_rd_data), .slot_cs_array(slot_cs8),
    .slot_mem_wr_array(slot_wr8), .slot_mem_rd_array(slot_rd8_o),
    .slot_reg_addr_array(slot_addr8), .slot_wr_data_array(slot_wdat8),
    .slot_rd_data_array(slot_rd8), .err_clr(err_clr), .err_flag(err_flag8),
    .err_count(err_count8)
  );

  video_bus_bridge #(.N_SLOTS(6)) u6 (
    .clk(clk), .reset(reset), .video_cs(video_cs), .video_wr(video_wr), .video_rd(video_rd),
    .video_addr(video_addr), .video_wr_data(video_wr_data), .video_ready(ready6),
    .video_rd_valid(rd_valid6), .video_rd_data(rd_data6), .frame_cs(frame_cs6),
    .frame_wr(frame_wr6), .frame_rd(frame_rd6), .frame_addr(frame_addr6),
    .frame_wr_data(frame_wdat6), .frame_rd_data(frame_rd_data), .slot_cs_array(slot_cs6),
    .slot_mem_wr_array(slot_wr6), .slot_mem_rd_array(slot_rd6_o),
    .slot_reg_addr_array(slot_addr6), .slot_wr_data_array(slot_wdat6),
    .slot_rd_data_array(slot_rd6), .err_clr(err_clr), .err_flag(err_flag6),
    .err_count(err_count6)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic wr, input logic rd, input logic [20:0] addr, input logic [31:0] data);
    exp_t e;
    video_cs = 1'b1; video_wr = wr; video_rd = rd; video_addr = addr; video_wr_data = data;
    e.frame = addr[20];
    e.wr    = wr;
    e.idx   = int'(addr[16:14]);
    e.addr  = addr[20] ? addr[19:0] : {6'd0, addr[13:0]};
    e.data  = data;
    sq.push_back(e);
  endtask

  task automatic idle_bus();
    video_cs = 1'b0; video_wr = 1'b0; video_rd = 1'b0;
  endtask

  task automatic chk_rst(input string t);
    chk({t, "_ready"}, ready8, 1);
    chk({t, "_strobes"}, {frame_cs8, frame_wr8, frame_rd8, slot_cs8, slot_wr8, slot_rd8_o}, 0);
    chk({t, "_frame_addr"}, frame_addr8, 0);
    chk({t, "_slot_addr"}, slot_addr8, 0);
    chk({t, "_wdata"}, {frame_wdat8, slot_wdat8}, 0);
    chk({t, "_rd_valid"}, rd_valid8, 0);
    chk({t, "_rd_data"}, rd_data8, 0);
    chk({t, "_err"}, {err_flag8, err_count8, err_flag6, err_count6}, 0);
  endtask

  // Scoreboard on the 8-slot instance: every strobe cycle and every read response pops one entry.
  always @(negedge clk) begin
    if (mon_en) begin
      if (frame_cs8 || (slot_cs8 != 8'h00)) begin
        if (sq.size() == 0) begin
          chk("spurious_strobe", {frame_cs8, slot_cs8}, 0);
        end else begin
          me = sq.pop_front();
          oh = me.frame ? 8'h00 : (8'h01 << me.idx);
          chk("strobes", {frame_cs8, frame_wr8, frame_rd8, slot_cs8, slot_wr8, slot_rd8_o},
              {me.frame, me.frame && me.wr, me.frame && !me.wr, oh, me.wr ? oh : 8'h00, me.wr ? 8'h00 : oh});
          if (me.frame) begin
            chk("frame_addr", frame_addr8, me.addr);
            if (me.wr) chk("frame_wdata", frame_wdat8, me.data);
          end else begin
            chk("slot_addr", slot_addr8[me.idx*14 +: 14], me.addr[13:0]);
            if (me.wr) chk("slot_wdata", slot_wdat8[me.idx*32 +: 32], me.data);
          end
        end
      end
      if (rd_valid8) begin
        if (rq.size() == 0) chk("unexpected_rd_valid", rd_valid8, 0);
        else chk("rd_data", rd_data8, rq.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; err_clr = 1'b0;
    video_addr = '0; video_wr_data = '0;
    idle_bus();
    frame_rd_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 8; i++) slot_rd8[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    slot_rd6 = slot_rd8[191:0];
    repeat (3) @(negedge clk);
    chk_rst("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Slot write: slot 3, register 5
    req(1'b1, 1'b0, 21'h0C005, 32'h1234_5678);
    @(negedge clk); idle_bus();
    chk("sw_slot_cs", slot_cs8, 8'h08);
    chk("sw_slot_wr", slot_wr8, 8'h08);
    chk("sw_reg3", slot_addr8[3*14 +: 14], 14'h0005);
    chk("sw_frame_cs", frame_cs8, 0);
    chk("sw_ready", ready8, 1);
    chk("sw_slot_cs6", slot_cs6, 6'h08);
    repeat (2) @(negedge clk);

    // Frame read, data valid only in the last WAIT cycle
    req(1'b0, 1'b1, 21'h100040, 32'h0);
    rq.push_back(32'hCAFE_0001);
    @(negedge clk); idle_bus();
    chk("fr_ready_t1", ready8, 0);
    chk("fr_frame_addr", frame_addr8, 20'h00040);
    @(negedge clk);
    chk("fr_ready_t2", ready8, 0);
    chk("fr_valid_t2", rd_valid8, 0);
    frame_rd_data = 32'hCAFE_0001;
    @(negedge clk);
    frame_rd_data = 32'hDEAD_BEEF;
    chk("fr_valid_t3", rd_valid8, 1);
    chk("fr_ready_t3", ready8, 1);
    @(negedge clk);
    chk("fr_valid_t4", rd_valid8, 0);
    chk("fr_data_hold", rd_data8, 32'hCAFE_0001);
    @(negedge clk);

    // Back-to-back writes alternating slot 0 and frame; the third also has video_rd high
    req(1'b1, 1'b0, 21'h00010, 32'h1111_0000);
    @(negedge clk); chk("b2b_ready1", ready8, 1);
    req(1'b1, 1'b0, 21'h100020, 32'h2222_0000);
    @(negedge clk); chk("b2b_ready2", ready8, 1);
    req(1'b1, 1'b1, 21'h00011, 32'h3333_0000);
    @(negedge clk); chk("b2b_ready3", ready8, 1);
    req(1'b1, 1'b0, 21'h100021, 32'h4444_0000);
    @(negedge clk); idle_bus(); chk("b2b_ready4", ready8, 1);
    repeat (2) @(negedge clk);

    // Read of slot 7: unpopulated on the 6-slot instance
    chk("unpop_cnt_before", err_count6, 0);
    req(1'b0, 1'b1, 21'h1C000, 32'h0);
    rq.push_back(32'hA000_0007);
    @(negedge clk); idle_bus();
    chk("unpop_no_cs", {frame_cs6, slot_cs6, slot_rd6_o}, 0);
    chk("unpop_flag", err_flag6, 1);
    chk("unpop_count", err_count6, 1);
    @(negedge clk);
    chk("unpop_valid_t2", rd_valid6, 0);
    @(negedge clk);
    chk("unpop_valid_t3", rd_valid6, 1);
    chk("unpop_data_t3", rd_data6, 0);
    repeat (2) @(negedge clk);

    // Error event together with err_clr, then err_clr alone
    req(1'b1, 1'b0, 21'h18000, 32'h0000_0066);
    err_clr = 1'b1;
    @(negedge clk); idle_bus(); err_clr = 1'b0;
    chk("clr_evt_flag", err_flag6, 1);
    chk("clr_evt_count", err_count6, 2);
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("clr_flag", err_flag6, 0);
    chk("clr_count_kept", err_count6, 2);
    @(negedge clk);

    // Drive the counter to saturation
    mon_en = 1'b0;
    for (int n = 0; n < 65533; n++) begin
      video_cs = 1'b1; video_wr = 1'b1; video_rd = 1'b0;
      video_addr = 21'h18000; video_wr_data = 32'(n);
      @(negedge clk);
    end
    idle_bus();
    chk("sat_reach", err_count6, 16'hFFFF);
    chk("sat_flag", err_flag6, 1);
    video_cs = 1'b1; video_wr = 1'b1;
    @(negedge clk); idle_bus();
    chk("sat_hold", err_count6, 16'hFFFF);
    chk("pop8_no_err", {err_flag8, err_count8}, 0);
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);

    // Reset during WAIT of a slot read
    req(1'b0, 1'b1, 21'h08004, 32'h0);
    @(negedge clk); idle_bus();
    chk("mid_ready_wait", ready8, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_rst("mid_reset");
    @(negedge clk);
    chk("mid_no_valid", rd_valid8, 0);
    chk("mid_no_valid6", rd_valid6, 0);
    repeat (4) @(negedge clk);

    chk("strobe_queue_empty", sq.size(), 0);
    chk("read_queue_empty", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
